// File: rtl/ofdm_subcarrier_map_pkg.sv
// Shared constants, types and the bin-to-data-index map for the OFDM subcarrier mapper.
package ofdm_pkg;
    localparam int N_FFT  = 64;
    localparam int N_DATA = 48;

    localparam logic [5:0] PILOT_B0 = 6'd7;
    localparam logic [5:0] PILOT_B1 = 6'd21;
    localparam logic [5:0] PILOT_B2 = 6'd43;
    localparam logic [5:0] PILOT_B3 = 6'd57;
    localparam logic [5:0] GUARD_LO = 6'd27;
    localparam logic [5:0] GUARD_HI = 6'd37;

    localparam logic [15:0] PILOT_POS = 16'h7FFF;
    localparam logic [15:0] PILOT_NEG = 16'h8001;
    localparam logic [6:0]  LFSR_SEED = 7'h7F;

    typedef enum logic {RD_IDLE, RD_RUN} rd_state_e;
    typedef enum logic [1:0] {BIN_ZERO, BIN_DATA, BIN_PPOS, BIN_PNEG} bin_kind_e;

    typedef struct packed {
        bin_kind_e  kind;
        logic [5:0] k;
    } bin_map_t;

    // Bin 21 is the only pilot carried with inverted polarity.
    function automatic bin_map_t map_bin(input logic [5:0] b);
        bin_map_t m;
        m.kind = BIN_ZERO;
        m.k    = '0;
        if (b == PILOT_B0 || b == PILOT_B2 || b == PILOT_B3) begin
            m.kind = BIN_PPOS;
        end else if (b == PILOT_B1) begin
            m.kind = BIN_PNEG;
        end else if (b != 6'd0 && !(b >= GUARD_LO && b <= GUARD_HI)) begin
            m.kind = BIN_DATA;
            if (b < PILOT_B0)      m.k = b + 6'd23;
            else if (b < PILOT_B1) m.k = b + 6'd22;
            else if (b < GUARD_LO) m.k = b + 6'd21;
            else if (b < PILOT_B2) m.k = b - 6'd38;
            else if (b < PILOT_B3) m.k = b - 6'd39;
            else                   m.k = b - 6'd40;
        end
        return m;
    endfunction
endpackage

// File: rtl/ofdm_subcarrier_map_if.sv
// Streaming bus between modulator, subcarrier mapper and IFFT; symb_last marks OFDM symbol edges.
interface ofdm_subcarrier_map_if #(parameter int DW = 16);
    logic            tvalid;
    logic            tready;
    logic            tlast;
    logic            symb_last;
    logic [2*DW-1:0] tdata;

    modport master (output tvalid, tdata, tlast, symb_last, input tready);
    modport slave  (input tvalid, tdata, tlast, symb_last, output tready);
endinterface

// File: rtl/ofdm_subcarrier_map_lfsr.sv
// 127-length pilot polarity generator; p=1 means positive pilot for the current symbol.
module ofdm_pilot_lfsr
    import ofdm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic reload,
    output logic p
);
    logic [6:0] s;
    logic       fb;

    assign fb = s[6] ^ s[3];
    assign p  = ~fb;

    always_ff @(posedge clk) begin
        if (!rst)        s <= LFSR_SEED;
        else if (reload) s <= LFSR_SEED;
        else if (step)   s <= {s[5:0], fb};
    end
endmodule

// File: rtl/ofdm_subcarrier_map.sv
// Ping-pong buffer of 48 data symbols, drained as 64 IFFT bins with pilots, DC and guards inserted.
module ofdm_subcarrier_map
    import ofdm_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    ofdm_subcarrier_map_if.slave        s_axis,
    ofdm_subcarrier_map_if.master       m_axis,
    output logic                        err_symb
);
    localparam logic [5:0] K_LAST = 6'(N_DATA - 1);
    localparam logic [5:0] B_LAST = 6'(N_FFT - 1);

    logic [2*DW-1:0] mem [2][N_DATA];
    logic [5:0]      wk, b;
    logic            wb, rb, rdy_en;
    logic [1:0]      full, full_nxt, tl_lat;
    logic            acc, wr_done, adv, ld, rel, p;
    rd_state_e       st, st_nxt;
    bin_map_t        bm;
    logic [2*DW-1:0] sample;

    // Write side
    assign s_axis.tready = rdy_en && !full[wb];
    assign acc           = s_axis.tvalid && s_axis.tready;
    assign wr_done       = acc && (wk == K_LAST);

    always_ff @(posedge clk) begin
        if (acc) mem[wb][wk] <= s_axis.tdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wk       <= '0;
            wb       <= 1'b0;
            rdy_en   <= 1'b0;
            err_symb <= 1'b0;
            tl_lat   <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (acc) begin
                // Framing follows wk alone; a misplaced marker only raises the flag.
                if (s_axis.symb_last != (wk == K_LAST)) err_symb <= 1'b1;
                wk <= wr_done ? 6'd0 : wk + 6'd1;
            end
            if (wr_done) begin
                tl_lat[wb] <= s_axis.tlast;
                wb         <= ~wb;
            end
        end
    end

    // Set and release can hit different banks in the same cycle; both take effect.
    always_comb begin
        full_nxt = full;
        if (rel)     full_nxt[rb] = 1'b0;
        if (wr_done) full_nxt[wb] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) full <= '0;
        else      full <= full_nxt;
    end

    // Read FSM
    assign adv = !m_axis.tvalid || m_axis.tready;

    always_ff @(posedge clk) begin
        if (!rst) st <= RD_IDLE;
        else      st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            RD_IDLE: if (full[rb]) st_nxt = RD_RUN;
            RD_RUN:  if (rel && !full[~rb]) st_nxt = RD_IDLE;
            default: st_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        ld  = (st == RD_RUN) && adv;
        rel = ld && (b == B_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            b  <= '0;
            rb <= 1'b0;
        end else begin
            if (st == RD_IDLE) b <= '0;
            else if (ld)       b <= b + 6'd1;
            if (rel)           rb <= ~rb;
        end
    end

    ofdm_pilot_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .step   (rel),
        .reload (rel && tl_lat[rb]),
        .p      (p)
    );

    assign bm = map_bin(b);

    always_comb begin
        sample = '0;
        case (bm.kind)
            BIN_DATA: sample = mem[rb][bm.k];
            BIN_PPOS: sample = {{DW{1'b0}}, DW'(p ? PILOT_POS : PILOT_NEG)};
            BIN_PNEG: sample = {{DW{1'b0}}, DW'(p ? PILOT_NEG : PILOT_POS)};
            default:  sample = '0;
        endcase
    end

    // Output register holds while the IFFT stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_axis.tvalid    <= 1'b0;
            m_axis.tdata     <= '0;
            m_axis.tlast     <= 1'b0;
            m_axis.symb_last <= 1'b0;
        end else if (adv) begin
            m_axis.tvalid <= ld;
            if (ld) begin
                m_axis.tdata     <= sample;
                m_axis.tlast     <= tl_lat[rb] && (b == B_LAST);
                m_axis.symb_last <= (b == B_LAST);
            end
        end
    end
endmodule

// File: doc/ofdm_subcarrier_map.md
# ofdm_subcarrier_map

Sits directly downstream of the QPSK modulator and upstream of the 64-point IFFT. It collects 48 modulated data symbols per OFDM symbol and places them on data subcarriers ±1..±26 in IFFT input order. It inserts four BPSK pilots, with polarity taken from the 127-length pilot sequence, and fills DC and guard bins with zero. Two-bank ping-pong buffering lets the next symbol fill while the current one drains.

## Interface
- DW, 16, I/Q component width
- clk  in  1  clock
- rst  in  1  synchronous reset, active low
- s_axis_tvalid  in  1  input sample valid
- s_axis_tdata  in  2*DW  {Q,I} modulated data symbol
- s_axis_tlast  in  1  last symbol of packet (coincides with s_bit_symb_last)
- s_axis_tready  out  1  input ready
- s_bit_symb_last  in  1  marks the 48th data symbol of an OFDM symbol
- m_axis_tvalid  out  1  output sample valid
- m_axis_tdata  out  2*DW  {Q,I} IFFT bin sample
- m_axis_tlast  out  1  bin 63 of the packet's final OFDM symbol
- m_axis_tready  in  1  IFFT ready
- m_bit_symb_last  out  1  bin 63 of every OFDM symbol
- err_symb  out  1  sticky framing error

## Operation
- Write side:
  - Counter wk 0..47; each accepted input is written to bank wb, address wk.
  - On wk==47 accept: bank wb is marked full, its tlast flag is latched, wk←0, wb toggles.
- s_axis_tready = !full[wb]. If both banks are full, input stalls.
- Read side FSM:
  - IDLE: on full[rb], go to RUN with rd bin b←0.
  - RUN: emits b=0..63. At b==63 accept: full[rb]←0, rb toggles, pilot LFSR steps. Next state is RUN if full[new rb], else IDLE.
- Bin map (k = data index):
  - b0, b27–37: zero.
  - b1–6: k=b+23. b8–20: k=b+22. b22–26: k=b+21.
  - b38–42: k=b−38. b44–56: k=b−39. b58–63: k=b−40.
  - Pilots: b7, b43, b57 = +p; b21 = −p.
  - Pilot value is I=±16'h7FFF (−p uses 16'h8001), Q=0.
- Pilot LFSR: 7 bits, seed 7'h7F, fb=s[6]^s[3], s←{s[5:0],fb}.
  - p=+1 when the current fb==0, else −1.
  - Steps once per output OFDM symbol.
  - Reloads the seed after emitting a symbol whose latched tlast=1.
  - Resulting p sequence is +,+,+,+,−,−,−,+,… .
- Framing check: err_symb←1 if s_bit_symb_last=1 at wk≠47, or 0 at wk==47, on an accepted beat. Framing is still driven by wk only. err_symb clears only on reset.
- m_axis_tlast = latched tlast of rb at b==63. m_bit_symb_last = (b==63).

## Timing
- Reset (rst=0 at clk edge):
  - Outputs: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_bit_symb_last=0, err_symb=0.
  - Internal: wk=0, wb=rb=0, full=2'b00, LFSR=7'h7F, FSM=IDLE.
  - s_axis_tready rises the first cycle after reset release.
  - Reset mid-operation discards all buffered data; no partial symbol is emitted.
- Output is registered and updates when !m_axis_tvalid || m_axis_tready. Data is held stable while m_axis_tvalid && !m_axis_tready.
- Latency: bin 0 is valid 2 cycles after the 48th input beat is accepted.
- Back-to-back symbols: bin 0 of the next symbol directly follows bin 63 with no bubble when its bank is already full.
- Simultaneous completion of a bank write and a bank read in one cycle: both flag updates apply; the released bank is writable the next cycle.
- Sustained rate is 48 in / 64 out, so the input side is throttled by the output.

## Structure
- Shared package ofdm_pkg holds:
  - N_FFT=64, N_DATA=48.
  - Pilot bin constants 7, 21, 43, 57.
  - Guard range 27–37.
  - PILOT_POS=16'h7FFF, PILOT_NEG=16'h8001.
  - LFSR seed 7'h7F.
  - Read-FSM state enum.
- One sub-module, ofdm_pilot_lfsr, provides step, reload and p outputs.
- Bin-to-k mapping is a combinational function in the package.

## Test plan
- Single symbol, inputs k=0..47 with I=k, Q=0x100+k, m_axis_tready=1:
  - b0=0, b1 I=24, b7=0x7FFF, b21 I=0x8001, b38 I=0, b63 I=23, b27–37 zero.
  - m_bit_symb_last and m_axis_tlast asserted at b63 only.
- 6 back-to-back symbols, tlast on the 6th:
  - Pilot b7 I=+,+,+,+,−,− across symbols.
  - No output bubble between symbols.
  - s_axis_tready drops while both banks are full.
  - The next packet's first symbol restarts at p=+1.
- Random m_axis_tready (50%) over 10 symbols:
  - Output sequence identical to the tready=1 run.
  - Data held stable during stalls.
- s_bit_symb_last asserted at k=30:
  - err_symb=1 and stays set.
  - Bin layout unchanged.
- rst=0 asserted after 20 inputs of a symbol:
  - All outputs return to reset values.
  - The next full symbol maps correctly with p=+1.
- Simultaneous bank write completion and read release in the same cycle:
  - No lost or duplicated symbol.
  - full flags are correct the next cycle.
